// File: rtl/cwru_transceiver_rx.sv
// Receiver half of the CWRU key-code link. Deserialises 8-bit on/off-keyed
// frames (MSB first, start bit = 1) from one GPIO pin. It decodes the key index
// and shows it on a seven-segment display (active-low segments).
module cwru_transceiver_rx #(
  parameter int unsigned BIT_CYCLES  = 6250,
  parameter int unsigned HALF_CYCLES = 3125,
  parameter int unsigned DATA_PIN    = 17
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [35:0] GPIO_1,
  output logic [6:0]  HEX0
);

  localparam logic [12:0] BitReload  = 13'(BIT_CYCLES - 1);
  localparam logic [12:0] HalfReload = 13'(HALF_CYCLES - 1);

  localparam logic [6:0] SegDigit0 = 7'b1000000;
  localparam logic [6:0] SegDigit1 = 7'b1111001;
  localparam logic [6:0] SegDigit2 = 7'b0100100;
  localparam logic [6:0] SegDigit3 = 7'b0110000;
  localparam logic [6:0] SegDash   = 7'b0111111;
  localparam logic [6:0] SegBlank  = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StStart, StData, StDone} state_e;

  state_e      state_q, state_d;
  logic [12:0] timer_q, timer_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  sreg_q, sreg_d;
  logic [6:0]  hex_q, hex_d;
  logic        rx_meta_q, rx_s_q, rx_s_d_q;
  logic        rise;
  logic [6:0]  seg;

  // Two-flop synchroniser plus one delay stage for rising-edge detection
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b0;
      rx_s_q    <= 1'b0;
      rx_s_d_q  <= 1'b0;
    end else begin
      rx_meta_q <= GPIO_1[DATA_PIN];
      rx_s_q    <= rx_meta_q;
      rx_s_d_q  <= rx_s_q;
    end
  end

  assign rise = rx_s_q & ~rx_s_d_q;

  // Map the received frame to a display pattern; unknown codes show a dash
  always_comb begin
    seg = SegDash;
    case (sreg_q)
      8'b1000_0000: seg = SegDigit0;
      8'b1010_0000: seg = SegDigit1;
      8'b1010_1000: seg = SegDigit2;
      8'b1010_1010: seg = SegDigit3;
      default:      seg = SegDash;
    endcase
  end

  // Receive FSM next-state: mid-bit sampling driven by a reloading down-counter
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    hex_d    = hex_q;
    unique case (state_q)
      StIdle: begin
        bitcnt_d = 4'd0;
        if (rise) begin
          timer_d = HalfReload;
          state_d = StStart;
        end
      end
      StStart: begin
        if (timer_q == 13'd0) begin
          if (rx_s_q) begin
            sreg_d   = {sreg_q[6:0], 1'b1};
            timer_d  = BitReload;
            bitcnt_d = 4'd1;
            state_d  = StData;
          end else begin
            // Line fell back before mid-start-bit: treat as a glitch
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - 13'd1;
        end
      end
      StData: begin
        if (timer_q == 13'd0) begin
          sreg_d   = {sreg_q[6:0], rx_s_q};
          bitcnt_d = bitcnt_q + 4'd1;
          timer_d  = BitReload;
          if (bitcnt_q == 4'd7) state_d = StDone;
        end else begin
          timer_d = timer_q - 13'd1;
        end
      end
      StDone: begin
        hex_d   = seg;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and datapath state registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      timer_q  <= 13'd0;
      bitcnt_q <= 4'd0;
      sreg_q   <= 8'd0;
      hex_q    <= SegBlank;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
      hex_q    <= hex_d;
    end
  end

  assign HEX0 = hex_q;

endmodule

// File: tb/tb_cwru_transceiver_rx.sv
// Directed bench for cwru_transceiver_rx with shortened bit timing.
module tb_cwru_transceiver_rx;

  localparam int unsigned B = 16;
  localparam int unsigned H = 8;
  localparam int unsigned Pin = 17;
  // Clock edges from driving the start bit until HEX0 shows the new value
  localparam int unsigned UpdEdge = 7 * B + H + 4;

  logic        clk;
  logic        rst_n;
  logic [35:0] gpio;
  logic [6:0]  hex;

  logic [6:0] exp_q[$];
  logic [6:0] hex_model;
  int checks;
  int failures;

  cwru_transceiver_rx #(
    .BIT_CYCLES (B),
    .HALF_CYCLES(H),
    .DATA_PIN   (Pin)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .GPIO_1(gpio),
    .HEX0  (hex)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; HEX0 must hold its old value one edge before the update
  // and show the queued expectation exactly at the update edge
  task automatic send_frame(input string tag, input logic [7:0] bits, input logic [6:0] exp);
    logic [6:0] want;
    int c;
    c = 0;
    exp_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      gpio[Pin] = bits[i];
      for (int k = 0; k < int'(B); k++) begin
        @(posedge clk);
        #1;
        c++;
        if (c == int'(UpdEdge) - 1) check({tag, "_pre"}, hex, hex_model);
        if (c == int'(UpdEdge)) begin
          want = exp_q.pop_front();
          check({tag, "_post"}, hex, want);
          hex_model = want;
        end
      end
    end
    gpio[Pin] = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    hex_model = 7'b1111111;
    gpio      = 36'h0;
    rst_n     = 1'b0;
    cycles(3);
    check("reset_blank", hex, 7'b1111111);
    rst_n = 1'b1;

    // Unused header pins toggling must not matter
    gpio[16] = 1'b1;
    gpio[18] = 1'b1;
    cycles(16 * B);
    check("idle_blank", hex, 7'b1111111);

    send_frame("key0", 8'b1000_0000, 7'b1000000);
    cycles(2 * B);
    send_frame("key1", 8'b1010_0000, 7'b1111001);
    cycles(4 * B);
    check("key1_hold", hex, hex_model);
    send_frame("key2", 8'b1010_1000, 7'b0100100);
    cycles(2 * B);
    send_frame("key3", 8'b1010_1010, 7'b0110000);
    cycles(2 * B);

    // Short high pulse that is gone by mid-start-bit
    gpio[Pin] = 1'b1;
    cycles(4);
    gpio[Pin] = 1'b0;
    cycles(10 * B);
    check("glitch_hold", hex, 7'b0110000);

    send_frame("dash", 8'b1111_0000, 7'b0111111);
    cycles(2 * B);

    // Abandon a KEY[3] frame by resetting during bit 4
    gpio[Pin] = 1'b1;
    cycles(B);
    gpio[Pin] = 1'b0;
    cycles(B);
    gpio[Pin] = 1'b1;
    cycles(B);
    gpio[Pin] = 1'b0;
    cycles(B / 2);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    hex_model = 7'b1111111;
    check("midreset_blank", hex, 7'b1111111);
    cycles(10 * B);
    check("midreset_noupd", hex, 7'b1111111);

    send_frame("after_reset", 8'b1010_1010, 7'b0110000);
    cycles(2 * B);
    send_frame("back_key0", 8'b1000_0000, 7'b1000000);
    cycles(2 * B);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
